axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave
Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI-lite data width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 32, AXI-lite address width in bits.
REQ-003 Parameter REG_ADDR_BITS, default 4, log2 of the register count (16 words).
REQ-004 Parameter ID_VALUE, default 32'h1C2A_0001, value of read-only register 0.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 s_axil_awaddr  in  ADDR_WIDTH  write address.
REQ-008 s_axil_awprot  in  3  ignored.
REQ-009 s_axil_awvalid / s_axil_awready  in / out  1 each  write-address handshake.
REQ-010 s_axil_wdata  in  DATA_WIDTH  write data.
REQ-011 s_axil_wstrb  in  DATA_WIDTH/8  byte write enables.
REQ-012 s_axil_wvalid / s_axil_wready  in / out  1 each  write-data handshake.
REQ-013 s_axil_bresp  out  2  write response.
REQ-014 s_axil_bvalid / s_axil_bready  out / in  1 each  write-response handshake.
REQ-015 s_axil_araddr  in  ADDR_WIDTH  read address.
REQ-016 s_axil_arprot  in  3  ignored.
REQ-017 s_axil_arvalid / s_axil_arready  in / out  1 each  read-address handshake.
REQ-018 s_axil_rdata, s_axil_rresp  out  DATA_WIDTH, 2  read data and read response.
REQ-019 s_axil_rvalid / s_axil_rready  out / in  1 each  read-data handshake.
Function
REQ-020 Word index = addr[REG_ADDR_BITS+1:2]; addr[1:0] ignored; addr[ADDR_WIDTH-1:REG_ADDR_BITS+2] nonzero = out of range.
REQ-021 Write FSM states: W_IDLE (awready=1, wready=1), W_HAVE_AW (awready=0, wready=1), W_HAVE_W (awready=1, wready=0), W_RESP (both 0, bvalid=1).
REQ-022 W_IDLE: AW and W handshakes in the same cycle -> W_RESP; AW only -> W_HAVE_AW; W only -> W_HAVE_W; an address/data beat is latched on its handshake.
REQ-023 W_HAVE_AW with W handshake, or W_HAVE_W with AW handshake -> W_RESP.
REQ-024 Register update occurs on the edge entering W_RESP; bvalid is high the following cycle (1-cycle latency from the last of AW/W).
REQ-025 Byte lane i is updated only when wstrb[i]=1; wstrb=0 gives an OKAY response with no change.
REQ-026 Write to index 0 is discarded, bresp=OKAY (2'b00); write out of range is discarded, bresp=SLVERR (2'b10).
REQ-027 W_RESP holds bvalid and bresp stable until bready=1, then -> W_IDLE on that edge.
REQ-028 Read FSM states: R_IDLE (arready=1, rvalid=0), R_DATA (arready=0, rvalid=1); an AR handshake -> R_DATA with rdata/rresp registered on that edge.
REQ-029 R_DATA holds rdata/rresp stable until rready=1, then -> R_IDLE; maximum throughput is one read per 2 cycles.
REQ-030 Read of index 0 returns ID_VALUE; out-of-range read returns rdata=0, rresp=SLVERR; otherwise rresp=OKAY.
REQ-031 Read and write FSMs are independent; an AR handshake on the same edge as a write commit to the same index returns pre-write data.
Reset
REQ-032 While rst_n=0: all registers=0, both FSMs idle, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-033 awready, wready and arready are forced to 0 during reset and on the first clk edge after rst_n rises (registered enable flag), then follow the FSM.
REQ-034 Reset asserted mid-transaction abandons it with no partial register write and no response issued.
Verification
REQ-035 AW=0x4 and W=0xDEADBEEF, strb=0xF, same cycle -> bvalid next cycle with bresp=00; read 0x4 -> rdata=0xDEADBEEF, rresp=00.
REQ-036 W first, AW 3 cycles later, bready held low 4 cycles -> awready/wready stay 0 and bresp stays stable until bready; then 0x8 updated.
REQ-037 Reg 0x4=0xDEADBEEF, write 0x11223344 with strb=0x5 -> read 0x4 returns 0xDE22BE44.
REQ-038 Write to 0x0 -> OKAY with no change; read 0x0 -> ID_VALUE; access to 0x40 -> SLVERR with rdata=0.
REQ-039 Reset pulsed while in W_HAVE_AW and R_DATA -> bvalid=rvalid=0 immediately, readies 0 for one post-reset cycle, all registers read 0.

---
 rtl/axil_reg_slave.sv | 192 +++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-lite register slave: 16 x 32-bit words, word 0 is a read-only ID.
// Independent write (AW/W/B) and read (AR/R) state machines; byte-lane strobes.
module axil_reg_slave #(
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          ADDR_WIDTH    = 32,
    parameter int unsigned          REG_ADDR_BITS = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h1C2A_0001
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic [2:0]                s_axil_awprot,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic [2:0]                s_axil_arprot,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_BITS;
    localparam int unsigned IDX_MSB    = REG_ADDR_BITS + 1;
    localparam int unsigned HI_LSB     = REG_ADDR_BITS + 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t                  w_state, w_next;
    r_state_t                  r_state, r_next;
    logic                      en;
    logic [ADDR_WIDTH-1:0]     aw_addr_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic [STRB_WIDTH-1:0]     w_strb_q;
    logic [DATA_WIDTH-1:0]     regs [NUM_REGS];

    logic                      aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]     wa_eff;
    logic [DATA_WIDTH-1:0]     wd_eff;
    logic [STRB_WIDTH-1:0]     ws_eff;
    logic [REG_ADDR_BITS-1:0]  w_idx, r_idx;
    logic                      w_oor, r_oor;
    logic                      unused_bits;

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid  & s_axil_wready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;

    // Address/data for the commit come from the latch if that beat arrived earlier
    assign wa_eff = (w_state == W_HAVE_AW) ? aw_addr_q : s_axil_awaddr;
    assign wd_eff = (w_state == W_HAVE_W)  ? w_data_q  : s_axil_wdata;
    assign ws_eff = (w_state == W_HAVE_W)  ? w_strb_q  : s_axil_wstrb;
    assign w_idx  = wa_eff[IDX_MSB:2];
    assign w_oor  = |wa_eff[ADDR_WIDTH-1:HI_LSB];
    assign r_idx  = s_axil_araddr[IDX_MSB:2];
    assign r_oor  = |s_axil_araddr[ADDR_WIDTH-1:HI_LSB];
    assign commit = (w_state != W_RESP) && (w_next == W_RESP);

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, wa_eff[1:0], s_axil_araddr[1:0]};

    // Ready enable: held low through reset and the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= 1'b0;
        else        en <= 1'b1;
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_HAVE_AW;
                else if (w_hs)     w_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)          w_next = W_RESP;
            W_HAVE_W:  if (aw_hs)         w_next = W_RESP;
            W_RESP:    if (s_axil_bready) w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs decoded from the registered state
    always_comb begin
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (w_state)
            W_IDLE:    begin s_axil_awready = en; s_axil_wready = en; end
            W_HAVE_AW: s_axil_wready  = en;
            W_HAVE_W:  s_axil_awready = en;
            W_RESP:    s_axil_bvalid  = 1'b1;
            default:   ;
        endcase
    end

    // Latch each write beat on its own handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= s_axil_awaddr;
            if (w_hs) begin
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
        end
    end

    // Register file update and write response on the edge entering W_RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            s_axil_bresp <= RESP_OKAY;
        end else if (commit) begin
            s_axil_bresp <= w_oor ? RESP_SLVERR : RESP_OKAY;
            if (!w_oor && (w_idx != '0)) begin
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                    if (ws_eff[b]) regs[w_idx][8*b +: 8] <= wd_eff[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)         r_next = R_DATA;
            R_DATA:  if (s_axil_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs decoded from the registered state
    always_comb begin
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  s_axil_arready = en;
            R_DATA:  s_axil_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read data/response captured on the AR handshake (sees pre-write contents)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rdata <= '0;
            s_axil_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            if (r_oor) begin
                s_axil_rdata <= '0;
                s_axil_rresp <= RESP_SLVERR;
            end else if (r_idx == '0) begin
                s_axil_rdata <= ID_VALUE;
                s_axil_rresp <= RESP_OKAY;
            end else begin
                s_axil_rdata <= regs[r_idx];
                s_axil_rresp <= RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a word-array reference model.
module tb_axil_reg_slave;

    localparam logic [31:0] ID = 32'h1C2A_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [16];

    axil_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_BITS(4), .ID_VALUE(ID)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: word array, word 0 is ID, anything above 0x3F is SLVERR
    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx = int'(addr[5:2]);
        if (addr[31:6] != 26'd0) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            if (idx != 0)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic mdl_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int idx;
        idx = int'(addr[5:2]);
        if (addr[31:6] != 26'd0) begin
            data = 32'h0;
            resp = 2'b10;
        end else begin
            data = (idx == 0) ? ID : mdl[idx];
            resp = 2'b00;
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    endtask

    // Write with independent AW/W start delays and a bready hold-off
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done;
        int cyc;
        logic [1:0] first;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            awvalid = !aw_done && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done  = 1;
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            chk("write_handshake_timeout", 32'(cyc), 32'd0);
            @(negedge clk);
            awvalid = 0; wvalid = 0;
            return;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("bvalid_latency", 32'(bvalid), 32'd1);
        first = bresp;
        for (int k = 0; k < b_dly; k++) begin
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("readies_low_in_resp", 32'({awready, wready}), 32'd0);
            chk("bresp_stable", 32'(bresp), 32'(first));
            @(negedge clk);
        end
        bready = 1;
        resp   = bresp;
        @(negedge clk);
        bready = 0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    // Read with an rready hold-off
    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit done;
        int cyc;
        logic [31:0] d0;
        logic [1:0]  r0;
        done = 0; cyc = 0; data = 32'hxxxx_xxxx; resp = 2'b11;
        while (!done && cyc < 40) begin
            @(negedge clk);
            arvalid = 1;
            araddr  = addr;
            if (arready) done = 1;
            cyc++;
        end
        @(negedge clk);
        arvalid = 0;
        if (!done) begin
            chk("read_handshake_timeout", 32'(cyc), 32'd0);
            return;
        end
        chk("rvalid_latency", 32'(rvalid), 32'd1);
        d0 = rdata; r0 = rresp;
        for (int k = 0; k < r_dly; k++) begin
            @(negedge clk);
            chk("rdata_stable", rdata, d0);
            chk("rresp_stable", 32'(rresp), 32'(r0));
        end
        rready = 1;
        data   = rdata;
        resp   = rresp;
        @(negedge clk);
        rready = 0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [1:0]  resp, mresp;
        logic [31:0] d, md;

        rst_n = 0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        mdl_clear();

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'h5, 32'h0,         2'b00};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hDE22_BE44, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, ID,            2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'hAAAA_5555, 4'hF, 32'h0,         2'b10};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[8]  = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 4'h0, 32'h0,         2'b00};
        vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 32'hDE22_BE44, 2'b00};
        vecs[10] = '{1'b1, 32'h0000_000C, 32'h0F0F_0F0F, 4'h8, 32'h0,         2'b00};
        vecs[11] = '{1'b0, 32'h0000_000F, 32'h0,         4'h0, 32'h0F00_0000, 2'b00};
        vecs[12] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[13] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h0,         2'b10};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
        rst_n = 1;
        #1;
        chk("post_rst_readies_low", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("post_rst_readies_high", 32'({awready, wready, arready}), 32'd7);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, (i + 2) % 3, i % 2, resp);
                chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                mdl_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
            end else begin
                do_read(vecs[i].addr, i % 2, d, resp);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end
        end

        // W first, AW three cycles later, bready held off four cycles
        do_write(32'h8, 32'h600D_F00D, 4'hF, 3, 0, 4, resp);
        chk("late_aw_bresp", 32'(resp), 32'd0);
        mdl_write(32'h8, 32'h600D_F00D, 4'hF, mresp);
        do_read(32'h8, 0, d, resp);
        chk("late_aw_rdata", d, 32'h600D_F00D);

        // AR handshake on the same edge as a write commit to the same word
        @(negedge clk);
        awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'h5A5A_A5A5; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h8;
        chk("same_edge_readies", 32'({awready, wready, arready}), 32'd7);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("same_edge_rvalid", 32'(rvalid), 32'd1);
        chk("same_edge_bvalid", 32'(bvalid), 32'd1);
        chk("same_edge_old_data", rdata, 32'h600D_F00D);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        mdl_write(32'h8, 32'h5A5A_A5A5, 4'hF, mresp);
        do_read(32'h8, 1, d, resp);
        chk("same_edge_new_data", d, 32'h5A5A_A5A5);

        // Reset mid-transaction: write holding an address, read holding data
        @(negedge clk);
        awvalid = 1; awaddr = 32'h10; arvalid = 1; araddr = 32'h4;
        @(negedge clk);
        awvalid = 0; arvalid = 0;
        chk("mid_rvalid", 32'(rvalid), 32'd1);
        chk("mid_have_aw_readies", 32'({awready, wready}), 32'b01);
        wvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        rst_n = 0;
        #1;
        chk("mid_rst_valids", 32'({bvalid, rvalid}), 32'd0);
        chk("mid_rst_readies", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        wvalid = 0;
        rst_n = 1;
        #1;
        chk("mid_post_rst_readies_low", 32'({awready, wready, arready}), 32'd0);
        chk("mid_post_rst_bvalid", 32'(bvalid), 32'd0);
        @(negedge clk);
        chk("mid_post_rst_readies_high", 32'({awready, wready, arready}), 32'd7);
        mdl_clear();
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 0, d, resp);
            mdl_read(32'(i * 4), md, mresp);
            chk($sformatf("post_rst_reg%0d", i), d, md);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            logic [31:0] addr, data;
            logic [3:0]  strb;
            addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(6, 31));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), resp);
                mdl_write(addr, data, strb, mresp);
                chk($sformatf("rnd%0d_bresp", n), 32'(resp), 32'(mresp));
            end else begin
                do_read(addr, $urandom_range(0, 3), d, resp);
                mdl_read(addr, md, mresp);
                chk($sformatf("rnd%0d_rdata", n), d, md);
                chk($sformatf("rnd%0d_rresp", n), 32'(resp), 32'(mresp));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
